// File: rtl/carry8_addsub_seq.sv
// Byte-serial add/subtract: one CARRY8 chain evaluation per cycle over NB_BYTES bytes,
// with fixed latency and result/flags registered only on completion.
module carry8_addsub_seq #(
  parameter int NB_BYTES = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    SUB,
  input  logic [8*NB_BYTES-1:0]   A,
  input  logic [8*NB_BYTES-1:0]   B,
  input  logic                    ABORT,
  output logic                    READY,
  output logic                    DONE,
  output logic [8*NB_BYTES-1:0]   SUM,
  output logic                    CARRY_OUT,
  output logic                    OVERFLOW
);
  localparam int W  = 8 * NB_BYTES;
  localparam int IW = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic            co_out_q, co_out_d, ov_q, ov_d;

  logic [7:0]      byte_a, byte_b, s, co, o;
  logic            c;

  // Single CARRY8 chain over the current byte: mux-carry with DI = A byte.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int k = 0; k < NB_BYTES; k++) begin
      if (idx_q == IW'(k)) begin
        byte_a = a_q[k*8 +: 8];
        byte_b = b_q[k*8 +: 8];
      end
    end
    s  = byte_a ^ byte_b;
    co = '0;
    c  = cy_q;
    for (int i = 0; i < 8; i++) begin
      co[i] = s[i] ? c : byte_a[i];
      c     = co[i];
    end
    o = s ^ {co[6:0], cy_q};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cy_d     = cy_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sum_d    = sum_q;
    co_out_d = co_out_q;
    ov_d     = ov_q;
    case (state_q)
      S_RUN: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else begin
          for (int k = 0; k < NB_BYTES; k++) begin
            if (idx_q == IW'(k)) res_d[k*8 +: 8] = o;
          end
          cy_d = co[7];
          if (idx_q == IW'(NB_BYTES - 1)) begin
            sum_d    = res_d;
            co_out_d = co[7];
            ov_d     = co[7] ^ co[6];
            state_d  = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation; ABORT has no effect here.
        if (START) begin
          a_d     = A;
          b_d     = B ^ {W{SUB}};
          cy_d    = SUB;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sum_q    <= '0;
      co_out_q <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cy_q     <= cy_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sum_q    <= sum_d;
      co_out_q <= co_out_d;
      ov_q     <= ov_d;
    end
  end

  assign READY     = (state_q != S_RUN);
  assign DONE      = (state_q == S_DONE);
  assign SUM       = sum_q;
  assign CARRY_OUT = co_out_q;
  assign OVERFLOW  = ov_q;
endmodule

// File: tb/tb_carry8_addsub_seq.sv
// Bench for carry8_addsub_seq: table-driven operations plus directed abort,
// back-to-back and mid-operation reset sequences, checked through a scoreboard queue.
module tb_carry8_addsub_seq;
  localparam int NB = 8;
  localparam int W  = 8 * NB;

  logic         CLK = 1'b0;
  logic         RST, START, SUB, ABORT;
  logic [W-1:0] A, B;
  logic         READY, DONE, CARRY_OUT, OVERFLOW;
  logic [W-1:0] SUM;

  carry8_addsub_seq #(.NB_BYTES(NB)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .A(A), .B(B), .ABORT(ABORT),
    .READY(READY), .DONE(DONE), .SUM(SUM), .CARRY_OUT(CARRY_OUT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] sum;
    logic         co, ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         co, ov;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0, failures = 0, cyc = 0;
  bit           busy = 0;
  logic [W-1:0] hold_sum = '0;
  logic         hold_co = 1'b0, hold_ov = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0]   r;
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    s  = r[W-1:0];
    co = r[W];
    ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // One clock: predict acceptance/abort/reset, then check the sampled outputs.
  task automatic step();
    bit   rst, acc, abt;
    int   c0;
    exp_t e;
    rst = RST;
    acc = START && !busy && !RST;
    abt = ABORT && busy && !RST;
    c0  = cyc;
    if (acc) begin
      model(A, B, SUB, e.sum, e.co, e.ov);
      e.cyc = c0 + NB + 1;
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      busy = 0;
      hold_sum = '0; hold_co = 1'b0; hold_ov = 1'b0;
    end else if (abt) begin
      void'(q.pop_back());
      busy = 0;
    end else if (acc) begin
      q.push_back(e);
      busy = 1;
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("done_pulse", {63'd0, DONE}, 64'd1);
      hold_sum = e.sum; hold_co = e.co; hold_ov = e.ov;
      busy = 0;
    end else begin
      chk("no_done", {63'd0, DONE}, 64'd0);
    end
    chk("ready", {63'd0, READY}, {63'd0, !busy});
    chk("sum", SUM, hold_sum);
    chk("carry_out", {63'd0, CARRY_OUT}, {63'd0, hold_co});
    chk("overflow", {63'd0, OVERFLOW}, {63'd0, hold_ov});
  endtask

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    START = 1'b1; A = a; B = b; SUB = sub;
    step();
    START = 1'b0;
  endtask

  // Runs until completion, scribbling on the operand inputs while busy.
  task automatic wait_done(input bit scribble);
    for (int i = 0; i < 4 * NB && busy; i++) begin
      if (scribble) begin
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; SUB = 1'($urandom);
      end
      step();
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL timeout cyc=%0d got=busy exp=done", cyc);
      q.delete();
      busy = 0;
    end
  endtask

  vec_t tbl[10];

  initial begin
    RST = 1'b1; START = 1'b0; SUB = 1'b0; ABORT = 1'b0; A = '0; B = '0;
    step(); step();
    RST = 1'b0;

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    tbl[1] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'd0, 1'b1, 1'b0};
    for (int i = 6; i < 10; i++) begin
      tbl[i].a = {$urandom, $urandom};
      tbl[i].b = {$urandom, $urandom};
      tbl[i].sub = 1'(i & 1);
      model(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sum, tbl[i].co, tbl[i].ov);
    end

    for (int i = 0; i < 10; i++) begin
      go(tbl[i].a, tbl[i].b, tbl[i].sub);
      wait_done(1'b1);
      chk("tbl_sum", SUM, tbl[i].sum);
      chk("tbl_co", {63'd0, CARRY_OUT}, {63'd0, tbl[i].co});
      chk("tbl_ov", {63'd0, OVERFLOW}, {63'd0, tbl[i].ov});
    end

    // Ignored START at cycle 3, ABORT at cycle 5, then a normal operation.
    ABORT = 1'b1; step(); ABORT = 1'b0;
    go(64'd5, 64'd3, 1'b0);
    step(); step();
    START = 1'b1; A = 64'hDEAD; B = 64'hBEEF; SUB = 1'b1;
    step();
    START = 1'b0;
    step();
    ABORT = 1'b1; START = 1'b1;
    step();
    ABORT = 1'b0; START = 1'b0;
    chk("abort_ready", {63'd0, READY}, 64'd1);
    chk("abort_sum_kept", SUM, tbl[9].sum);
    go(64'd5, 64'd3, 1'b0);
    wait_done(1'b0);
    chk("after_abort_sum", SUM, 64'd8);

    // Back-to-back: second START issued in the DONE cycle.
    go(64'd100, 64'd58, 1'b1);
    wait_done(1'b0);
    chk("b2b_done1", {63'd0, DONE}, 64'd1);
    chk("b2b_sum1", SUM, 64'd42);
    go(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
    wait_done(1'b1);
    chk("b2b_sum2", SUM, 64'd0);
    chk("b2b_co2", {63'd0, CARRY_OUT}, 64'd1);

    // Reset at cycle 4 of an operation.
    go(64'd7, 64'd9, 1'b0);
    step(); step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_ready", {63'd0, READY}, 64'd1);
    chk("rst_sum", SUM, 64'd0);
    for (int i = 0; i < NB + 3; i++) step();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/carry8_addsub_seq.md
CARRY8_ADDSUB_SEQ -- requirements
Module: carry8_addsub_seq

Interface
REQ-001 The block SHALL have parameter NB_BYTES, default 8, meaning the operand width in bytes (legal range 1..16).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit: request a new operation; accepted only when READY=1.
REQ-005 The block SHALL have port SUB, input, 1 bit: operation select sampled with START (0 = A+B, 1 = A-B).
REQ-006 The block SHALL have ports A and B, inputs, 8*NB_BYTES bits each: operands sampled with START.
REQ-007 The block SHALL have port ABORT, input, 1 bit: cancel an operation in progress.
REQ-008 The block SHALL have port READY, output, 1 bit: block can accept START this cycle.
REQ-009 The block SHALL have port DONE, output, 1 bit: one-cycle pulse, result valid.
REQ-010 The block SHALL have port SUM, output, 8*NB_BYTES bits: result.
REQ-011 The block SHALL have port CARRY_OUT, output, 1 bit: final carry (for SUB, 1 = no borrow).
REQ-012 The block SHALL have port OVERFLOW, output, 1 bit: signed overflow of the result.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE, with the transitions given in REQ-014 to REQ-020.
REQ-014 In IDLE and DONE, READY SHALL be 1; in RUN, READY SHALL be 0.
REQ-015 START=1 with READY=1 SHALL latch A, B xor {8*NB_BYTES{SUB}}, and SUB; clear byte index to 0; load carry register with SUB; and enter RUN.
REQ-016 In each RUN cycle, the block SHALL process byte k = index with a CARRY8 single-chain evaluation:
  - S = A[k] ^ B'[k], DI = A[k], CI = carry register.
  - O = S ^ {CO[6:0], CI} is written into result byte k.
  - The carry register is loaded with CO[7].
  - The index increments.
REQ-017 When index = NB_BYTES-1 in RUN, the block SHALL register the result onto SUM, set CARRY_OUT = CO[7] and OVERFLOW = CO[7]^CO[6], and enter DONE.
REQ-018 DONE SHALL be high for exactly one cycle; the state then returns to IDLE unless a new START is accepted in that cycle, in which case it goes directly to RUN.
REQ-019 Latency SHALL be fixed: DONE is asserted exactly NB_BYTES+1 cycles after the cycle in which START was accepted (9 cycles for NB_BYTES=8), independent of operand values.
REQ-020 SUM, CARRY_OUT and OVERFLOW SHALL change only on the DONE-setting edge and SHALL hold stable until the next completion; intermediate bytes are never visible on SUM.
REQ-021 START while READY=0 SHALL be ignored, with no effect on state or latched operands.
REQ-022 Operand changes on A/B/SUB after acceptance SHALL have no effect on the operation in progress.
REQ-023 ABORT=1 in RUN SHALL return to IDLE on the next edge with no DONE pulse and SUM/CARRY_OUT/OVERFLOW unchanged.
REQ-024 ABORT in IDLE or DONE SHALL be ignored, and ABORT SHALL take priority over START in the same cycle.
REQ-025 The byte index counter SHALL be ceil(log2(NB_BYTES)) bits (minimum 1) and never wrap in normal operation.
REQ-026 With NB_BYTES=1, the first RUN cycle SHALL also be the completing cycle.

Reset
REQ-027 RST=1 at a rising edge SHALL force state IDLE, index 0, carry register 0, READY=1, DONE=0, SUM=0, CARRY_OUT=0, OVERFLOW=0.
REQ-028 RST SHALL override START and ABORT, and mid-operation SHALL discard the operation with no DONE pulse.

Verification
REQ-029 Reset check: apply RST for 2 cycles -> READY=1, DONE=0, SUM=0, CARRY_OUT=0, OVERFLOW=0.
REQ-030 Add with full carry ripple (NB_BYTES=8): A=0xFFFFFFFFFFFFFFFF, B=1, SUB=0 -> DONE in cycle 9 after START, SUM=0, CARRY_OUT=1, OVERFLOW=0.
REQ-031 Subtract with borrow: A=0, B=1, SUB=1 -> SUM=0xFFFFFFFFFFFFFFFF, CARRY_OUT=0, OVERFLOW=0.
REQ-032 Signed overflow: A=0x7FFFFFFFFFFFFFFF, B=1, SUB=0 -> SUM=0x8000000000000000, OVERFLOW=1, CARRY_OUT=0.
REQ-033 Ignored START and abort: START again at cycle 3 with different operands, then ABORT at cycle 5 -> no DONE, READY=1 at cycle 6, SUM keeps previous result; next START then completes normally.
REQ-034 Back-to-back and mid-operation reset:
  - START asserted in the DONE cycle -> second DONE exactly 9 cycles later with the correct second result.
  - RST at cycle 4 of an operation -> no DONE, all outputs at reset values.
